// File: rtl/alloc_pkg.sv
// Shared types for the allocation stage: uop/rename/nuke packets, RS ids, FSM states.
package alloc_pkg;

  localparam int RS_ID_W = 1;
  typedef logic [RS_ID_W-1:0] t_rs_id;
  localparam t_rs_id RS_ALU = 1'b0;
  localparam t_rs_id RS_MEM = 1'b1;

  typedef enum logic {RUN, QUIESCE} t_alloc_state;

  localparam logic [5:0] OP_LOAD  = 6'h03;
  localparam logic [5:0] OP_STORE = 6'h23;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [15:0] imm;
  } t_uinstr;

  typedef struct packed {
    logic [5:0] pdst;
    logic [5:0] psrc1;
    logic [5:0] psrc2;
    logic [4:0] robid;
  } t_rename_pkt;

  typedef struct packed {
    logic       valid;
    logic [4:0] robid;
  } t_nuke_pkt;

  function automatic t_rs_id f_rs_select(input t_uinstr u);
    return (u.opcode == OP_LOAD || u.opcode == OP_STORE) ? RS_MEM : RS_ALU;
  endfunction

endpackage

// File: rtl/alloc_rs_credit.sv
// Free-entry credit counter for one reservation station; saturates at RS_DEPTH.
module alloc_rs_credit #(
  parameter  int RS_DEPTH = 8,
  localparam int CREDIT_W = $clog2(RS_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_alloc,
  input  logic                i_dealloc,
  input  logic                i_reload,
  output logic [CREDIT_W-1:0] o_credit
);

  localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(RS_DEPTH);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

  logic [CREDIT_W-1:0] r_credit;

  // Reload wins: the RS is flushed by the same nuke, so it is empty again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_credit <= FULL;
    else if (i_reload)                               r_credit <= FULL;
    else if (i_alloc && !i_dealloc)                  r_credit <= r_credit - ONE;
    else if (!i_alloc && i_dealloc && r_credit != FULL) r_credit <= r_credit + ONE;
  end

  assign o_credit = r_credit;

  a_no_overfree: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_dealloc && !i_alloc && !i_reload && r_credit == FULL));
  a_range: assert property (@(posedge clk) disable iff (!rst_n) r_credit <= FULL);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_alloc && r_credit == '0));

endmodule

// File: rtl/alloc.sv
// Allocation stage: steers renamed uops to reservation stations under credit control,
// with a short quiesce window after a nuke.
module alloc
  import alloc_pkg::*;
#(
  parameter  int NUM_RS       = 2,
  parameter  int RS_DEPTH     = 8,
  parameter  int NUKE_QUIESCE = 2,
  localparam int CREDIT_W     = $clog2(RS_DEPTH + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  t_nuke_pkt                        nuke_rb1,
  input  logic                             valid_rn1,
  input  t_uinstr                          uinstr_rn1,
  input  t_rename_pkt                      rename_rn1,
  output logic                             alloc_ready_ra0,
  input  logic [NUM_RS-1:0]                rs_dealloc_rsx,
  output logic [NUM_RS-1:0]                valid_ra1,
  output t_uinstr                          uinstr_ra1,
  output t_rename_pkt                      rename_ra1,
  output logic [NUM_RS-1:0][CREDIT_W-1:0]  credits_ra0
);

  localparam int             QW    = (NUKE_QUIESCE > 1) ? $clog2(NUKE_QUIESCE) : 1;
  localparam logic [QW-1:0]  QINIT = QW'((NUKE_QUIESCE > 0) ? NUKE_QUIESCE - 1 : 0);

  t_alloc_state      r_state, w_state_nxt;
  logic [QW-1:0]     r_qcnt, w_qcnt_nxt;
  logic              w_nuke, w_ready, w_accept;
  t_rs_id            w_rs_sel;
  logic [NUM_RS-1:0] w_alloc, w_dealloc, w_credit_nz;
  logic              w_unused_robid;

  assign w_nuke         = nuke_rb1.valid;
  assign w_unused_robid = ^nuke_rb1.robid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_qcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qcnt  <= w_qcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_qcnt_nxt  = r_qcnt;
    if (w_nuke) begin
      w_state_nxt = (NUKE_QUIESCE > 0) ? QUIESCE : RUN;
      w_qcnt_nxt  = QINIT;
    end else if (r_state == QUIESCE) begin
      if (r_qcnt == '0) w_state_nxt = RUN;
      else              w_qcnt_nxt  = r_qcnt - QW'(1);
    end
  end

  // Ready ignores the incoming uop so the rename skid hold has no comb loop.
  assign w_ready         = reset & (r_state == RUN) & ~w_nuke & (&w_credit_nz);
  assign alloc_ready_ra0 = w_ready;
  assign w_accept        = valid_rn1 & w_ready;
  assign w_rs_sel        = f_rs_select(uinstr_rn1);

  for (genvar i = 0; i < NUM_RS; i++) begin : g_rs
    assign w_alloc[i]     = w_accept && (w_rs_sel == t_rs_id'(i));
    assign w_dealloc[i]   = rs_dealloc_rsx[i] && (r_state == RUN);
    assign w_credit_nz[i] = |credits_ra0[i];

    alloc_rs_credit #(.RS_DEPTH(RS_DEPTH)) u_credit (
      .clk      (clk),
      .rst_n    (reset),
      .i_alloc  (w_alloc[i]),
      .i_dealloc(w_dealloc[i]),
      .i_reload (w_nuke),
      .o_credit (credits_ra0[i])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_ra1  <= '0;
      uinstr_ra1 <= '0;
      rename_ra1 <= '0;
    end else begin
      valid_ra1 <= w_alloc;
      if (w_accept) begin
        uinstr_ra1 <= uinstr_rn1;
        rename_ra1 <= rename_rn1;
      end
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(valid_ra1));

endmodule

// File: tb/tb_alloc.sv
// Table-driven bench for alloc with a scoreboard of expected RA1 outputs.
module tb_alloc;
  import alloc_pkg::*;

  localparam int NUM_RS = 2, RS_DEPTH = 8, NQ = 2, CW = 4;

  logic                       clk, reset;
  t_nuke_pkt                  nuke_rb1;
  logic                       valid_rn1;
  t_uinstr                    uinstr_rn1;
  t_rename_pkt                rename_rn1;
  logic                       alloc_ready_ra0;
  logic [NUM_RS-1:0]          rs_dealloc_rsx;
  logic [NUM_RS-1:0]          valid_ra1;
  t_uinstr                    uinstr_ra1;
  t_rename_pkt                rename_ra1;
  logic [NUM_RS-1:0][CW-1:0]  credits_ra0;

  alloc #(.NUM_RS(NUM_RS), .RS_DEPTH(RS_DEPTH), .NUKE_QUIESCE(NQ)) dut (
    .clk            (clk),
    .reset          (reset),
    .nuke_rb1       (nuke_rb1),
    .valid_rn1      (valid_rn1),
    .uinstr_rn1     (uinstr_rn1),
    .rename_rn1     (rename_rn1),
    .alloc_ready_ra0(alloc_ready_ra0),
    .rs_dealloc_rsx (rs_dealloc_rsx),
    .valid_ra1      (valid_ra1),
    .uinstr_ra1     (uinstr_ra1),
    .rename_ra1     (rename_ra1),
    .credits_ra0    (credits_ra0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       v;
    bit       mem;
    bit [1:0] dl;
    bit       nk;
    bit       er;
    int       c0;
    int       c1;
  } vec_t;

  typedef struct {
    logic [1:0]  vld;
    t_uinstr     u;
    t_rename_pkt r;
  } exp_t;

  vec_t tv[$];
  exp_t sb[$];
  exp_t last;
  int   n_vec, n_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input bit v, input bit mem, input bit [1:0] dl, input bit nk,
                      input bit er, input int c0, input int c1);
    vec_t t;
    t.v = v; t.mem = mem; t.dl = dl; t.nk = nk; t.er = er; t.c0 = c0; t.c1 = c1;
    tv.push_back(t);
  endtask

  // Called right after a negedge: drive, check ready, clock once, check RA1/credits.
  task automatic apply(input vec_t t, input int idx);
    t_uinstr     u;
    t_rename_pkt r;
    exp_t        e;
    logic [31:0] rr;
    logic [5:0]  alu_ops [3];
    alu_ops[0] = 6'h13; alu_ops[1] = 6'h33; alu_ops[2] = 6'h17;
    u.opcode = t.mem ? ((idx % 2 == 1) ? OP_STORE : OP_LOAD) : alu_ops[idx % 3];
    u.imm    = 16'(idx * 7 + 1);
    rr       = $urandom;
    r        = rr[22:0];
    valid_rn1      = t.v;
    uinstr_rn1     = u;
    rename_rn1     = r;
    rs_dealloc_rsx = t.dl;
    nuke_rb1.valid = t.nk;
    nuke_rb1.robid = 5'(idx);
    #1;
    chk($sformatf("ready[%0d]", idx), 64'(alloc_ready_ra0), 64'(t.er));
    if (t.v && t.er) begin
      last.u = u;
      last.r = r;
      e.vld  = t.mem ? 2'b10 : 2'b01;
    end else begin
      e.vld = 2'b00;
    end
    e.u = last.u;
    e.r = last.r;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("valid_ra1[%0d]", idx), 64'(valid_ra1), 64'(e.vld));
    chk($sformatf("uinstr_ra1[%0d]", idx), 64'(uinstr_ra1), 64'(e.u));
    chk($sformatf("rename_ra1[%0d]", idx), 64'(rename_ra1), 64'(e.r));
    chk($sformatf("credit0[%0d]", idx), 64'(credits_ra0[0]), 64'(t.c0));
    chk($sformatf("credit1[%0d]", idx), 64'(credits_ra0[1]), 64'(t.c1));
    n_vec++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec = 0; n_err = 0;
    last  = '{default: '0};
    reset = 1'b0; valid_rn1 = 1'b0; uinstr_rn1 = '0; rename_rn1 = '0;
    rs_dealloc_rsx = '0; nuke_rb1 = '0;

    // three back-to-back ALU uops
    for (int k = 0; k < 3; k++) addv(1, 0, 2'b00, 0, 1, 7 - k, 8);
    // fill the MEM RS, then a held 9th uop released by a dealloc
    for (int k = 0; k < 8; k++) addv(1, 1, 2'b00, 0, 1, 5, 7 - k);
    addv(1, 1, 2'b00, 0, 0, 5, 0);
    addv(1, 1, 2'b00, 0, 0, 5, 0);
    addv(1, 1, 2'b10, 0, 0, 5, 1);
    addv(1, 1, 2'b00, 0, 1, 5, 0);
    addv(0, 0, 2'b00, 0, 0, 5, 0);
    // refill MEM while allocating ALU; same-cycle alloc/dealloc on RS0 at credit 3
    addv(1, 0, 2'b10, 0, 0, 5, 1);
    addv(1, 0, 2'b10, 0, 1, 4, 2);
    addv(1, 0, 2'b10, 0, 1, 3, 3);
    addv(1, 0, 2'b01, 0, 1, 3, 3);
    addv(1, 0, 2'b10, 0, 1, 2, 4);
    // nuke with a valid uop at credits 2/4
    addv(1, 1, 2'b00, 1, 0, 8, 8);
    addv(1, 0, 2'b00, 0, 0, 8, 8);
    addv(1, 0, 2'b00, 0, 0, 8, 8);
    addv(1, 0, 2'b00, 0, 1, 7, 8);
    // nuke, re-nuke inside quiesce, dealloc ignored while quiescing
    addv(0, 0, 2'b00, 1, 0, 8, 8);
    addv(0, 0, 2'b00, 0, 0, 8, 8);
    addv(0, 0, 2'b00, 1, 0, 8, 8);
    addv(0, 0, 2'b11, 0, 0, 8, 8);
    addv(0, 0, 2'b00, 0, 0, 8, 8);
    addv(0, 0, 2'b00, 0, 1, 8, 8);
    // mixed traffic; ends with a MEM uop in flight
    addv(1, 1, 2'b00, 0, 1, 8, 7);
    addv(1, 0, 2'b01, 0, 1, 8, 7);
    addv(1, 1, 2'b10, 0, 1, 8, 7);
    addv(0, 0, 2'b10, 0, 1, 8, 8);
    addv(1, 1, 2'b00, 0, 1, 8, 7);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 64'(alloc_ready_ra0), 64'(0));
    chk("rst_valid", 64'(valid_ra1), 64'(0));
    chk("rst_credit0", 64'(credits_ra0[0]), 64'(RS_DEPTH));
    chk("rst_credit1", 64'(credits_ra0[1]), 64'(RS_DEPTH));
    n_vec++;
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

    // async reset mid-stream with valid_ra1=10 and no clock edge before the check
    valid_rn1 = 1'b0; rs_dealloc_rsx = '0; nuke_rb1 = '0;
    #2 reset = 1'b0;
    #1;
    chk("async_valid", 64'(valid_ra1), 64'(0));
    chk("async_uinstr", 64'(uinstr_ra1), 64'(0));
    chk("async_rename", 64'(rename_ra1), 64'(0));
    chk("async_ready", 64'(alloc_ready_ra0), 64'(0));
    chk("async_credit1", 64'(credits_ra0[1]), 64'(RS_DEPTH));
    n_vec++;
    @(negedge clk);
    reset = 1'b1;
    last  = '{default: '0};
    #1;
    chk("release_ready", 64'(alloc_ready_ra0), 64'(1));
    chk("release_credit0", 64'(credits_ra0[0]), 64'(RS_DEPTH));
    chk("release_credit1", 64'(credits_ra0[1]), 64'(RS_DEPTH));
    n_vec++;
    @(negedge clk);
    begin
      vec_t t;
      t.v = 1; t.mem = 0; t.dl = 2'b00; t.nk = 0; t.er = 1; t.c0 = 7; t.c1 = 8;
      apply(t, 100);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alloc.md
Name: alloc

Overview:
- Allocation stage directly downstream of rename.
- Consumes renamed uops from the rename skid output (`valid_rn1`, `uinstr_rn1`, `rename_rn1`) and steers each to one of `NUM_RS` reservation stations.
- Tracks per-RS free-entry credits and drives `alloc_ready_ra0`, which is rename's skid hold (hold = `~alloc_ready_ra0`).
- Runs a small post-nuke quiesce FSM so RSs can drain before allocation resumes.

Parameters:
- `NUM_RS`, 2, number of reservation stations (0 = ALU, 1 = MEM).
- `RS_DEPTH`, 8, entries per RS; also the credit reset value.
- `NUKE_QUIESCE`, 2, cycles that `alloc_ready_ra0` stays low after a nuke.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `nuke_rb1`  in  `t_nuke_pkt`  pipeline flush; only `.valid` is used
- `valid_rn1`  in  1  renamed uop valid
- `uinstr_rn1`  in  `t_uinstr`  renamed uop
- `rename_rn1`  in  `t_rename_pkt`  pdst/psrc/robid from rename
- `alloc_ready_ra0`  out  1  alloc can accept a uop this cycle
- `rs_dealloc_rsx`  in  `NUM_RS`  per-RS entry-freed pulse, at most one per RS per cycle
- `valid_ra1`  out  `NUM_RS`  one-hot RS write enable
- `uinstr_ra1`  out  `t_uinstr`  registered uop
- `rename_ra1`  out  `t_rename_pkt`  registered rename packet
- `credits_ra0`  out  `NUM_RS` x `CREDIT_W`  current credits (debug/perf)

Behaviour:
- Reset (`reset`==0, async):
  - `credit[i]` = `RS_DEPTH`.
  - `state` = RUN.
  - `valid_ra1` = 0, `uinstr_ra1` = 0, `rename_ra1` = 0.
  - `alloc_ready_ra0` = 0 while reset is asserted; 1 on the first cycle after release.
- `CREDIT_W` = `$clog2(RS_DEPTH+1)`, unsigned.
- Ready rule:
  - `alloc_ready_ra0` = (`state`==RUN) & ~`nuke_rb1.valid` & (`credit[i]` >= 1 for all i).
  - Conservative by design: no combinational dependency on `valid_rn1`/`uinstr_rn1`, which avoids a loop through the rename skid.
- Accept:
  - `accept_ra0` = `valid_rn1` & `alloc_ready_ra0`.
  - `rs_sel_ra0` = `f_rs_select(uinstr_rn1)`.
- RA1 register:
  - `valid_ra1` <= `accept_ra0` ? onehot(`rs_sel_ra0`) : 0.
  - `uinstr_ra1`/`rename_ra1` load only on `accept_ra0`; they hold otherwise.
  - Latency is 1 cycle, rn1 to ra1.
- Credits (state RUN):
  - `credit[i]` <= `credit[i]` - (`accept_ra0` & `rs_sel`==i) + `rs_dealloc_rsx[i]`.
  - Simultaneous alloc and dealloc on the same RS leaves the credit unchanged.
  - Underflow is impossible by construction (ready needs credit >= 1).
  - Dealloc when credit==`RS_DEPTH` is an assertion error; the credit saturates at `RS_DEPTH`.
- FSM, states RUN, QUIESCE:
  - RUN -> QUIESCE when `nuke_rb1.valid`:
    - `valid_ra1` is forced to 0 next cycle.
    - Any same-cycle accept is dropped; it is not counted against credits.
    - `qcnt` <= `NUKE_QUIESCE`-1.
    - All credits <= `RS_DEPTH`, because RSs flush on the same nuke.
  - QUIESCE:
    - `rs_dealloc_rsx` is ignored.
    - `qcnt` decrements; exit to RUN when `qcnt`==0.
    - A nuke during QUIESCE reloads `qcnt` and reloads credits.
  - When `NUKE_QUIESCE`==0, the FSM stays in RUN; credits still reload on nuke.
- No other state exists. A uop held in the rename skid while `alloc_ready_ra0`==0 is not sampled.
- Assertions:
  - `valid_ra1` is one-hot or zero.
  - `credit[i]` <= `RS_DEPTH`.
  - No accept while any credit==0.

Decomposition:
- `alloc_defs.pkg`:
  - `t_rs_id`, `RS_ALU`=0, `RS_MEM`=1.
  - `t_alloc_state` enum (RUN, QUIESCE).
  - `f_rs_select(t_uinstr)`: load/store opcodes -> `RS_MEM`, else `RS_ALU`.
- One natural sub-module: `rs_credit`, a single-RS saturating credit counter with alloc/dealloc/reload inputs, instantiated `NUM_RS` times via a generate loop.

Test Plan:
- Reset release, 3 ALU uops back-to-back:
  - `valid_ra1`=01 on 3 consecutive cycles, each 1 cycle after rn1.
  - `credit[0]`=5, `credit[1]`=8.
- 8 MEM uops with no dealloc:
  - `credit[1]`=0 and `alloc_ready_ra0`=0 from the cycle after the 8th accept.
  - A 9th uop is held until `rs_dealloc_rsx`=10, then accepted the following cycle.
- Same-cycle accept to RS0 with `rs_dealloc_rsx[0]`=1 at `credit[0]`=3 -> `credit[0]` stays 3.
- `nuke_rb1.valid` with `valid_rn1`=1 and credits 2/4:
  - `valid_ra1`=00 next cycle.
  - Credits become 8/8.
  - `alloc_ready_ra0` is low for 2 cycles, high on the 3rd.
- Nuke during QUIESCE -> `qcnt` restarts and ready stays low 2 more cycles; a dealloc pulse in QUIESCE leaves credits at 8.
- Async reset asserted mid-stream with `valid_ra1`=10:
  - Outputs clear immediately, without waiting for `clk`.
  - Credits = 8 on release.
